// File: rtl/frogger_pkg.sv
// Shared Frogger types: direction and hop-FSM enums, HID usage codes and key decoding.
package frogger_pkg;

  typedef enum logic [2:0] {
    DIR_UP    = 3'd0,
    DIR_DOWN  = 3'd1,
    DIR_LEFT  = 3'd2,
    DIR_RIGHT = 3'd3,
    DIR_NONE  = 3'd4
  } dir_t;

  typedef enum logic [1:0] {
    IDLE,
    HOP,
    DEAD
  } hop_state_t;

  localparam int CELL_PX = 32;

  localparam logic [7:0] KEY_W     = 8'h1A;
  localparam logic [7:0] KEY_S     = 8'h16;
  localparam logic [7:0] KEY_A     = 8'h04;
  localparam logic [7:0] KEY_D     = 8'h07;
  localparam logic [7:0] KEY_UP    = 8'h52;
  localparam logic [7:0] KEY_DOWN  = 8'h51;
  localparam logic [7:0] KEY_LEFT  = 8'h50;
  localparam logic [7:0] KEY_RIGHT = 8'h4F;

  function automatic dir_t decode_key(input logic [7:0] code);
    dir_t dir;
    case (code)
      KEY_W, KEY_UP:       dir = DIR_UP;
      KEY_S, KEY_DOWN:     dir = DIR_DOWN;
      KEY_A, KEY_LEFT:     dir = DIR_LEFT;
      KEY_D, KEY_RIGHT:    dir = DIR_RIGHT;
      default:             dir = DIR_NONE;
    endcase
    return dir;
  endfunction

  // The first key slot wins; the second slot is only consulted when the first is unmapped.
  function automatic dir_t decode_keycode(input logic [15:0] keycode);
    dir_t lo;
    lo = decode_key(keycode[7:0]);
    return (lo == DIR_NONE) ? decode_key(keycode[15:8]) : lo;
  endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// Brings the asynchronous VGA vertical sync into the Clk domain and emits a
// single-cycle pulse per frame on its rising edge.
module frame_tick_gen (
  input  logic Clk,
  input  logic Reset,
  input  logic frame_clk,
  output logic frame_tick
);

  logic sync1_q, sync2_q, sync3_q, tick_q;

  // Two synchronizer flops, one history flop for edge detect, then a registered pulse.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      sync1_q <= frame_clk;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
      tick_q  <= sync2_q & ~sync3_q;
    end
  end

  assign frame_tick = tick_q;

endmodule

// File: rtl/frog_hop_ctrl.sv
// Turns keyboard presses into grid-aligned frog hops animated over several frames,
// and runs the death/respawn sequence.
module frog_hop_ctrl
  import frogger_pkg::*;
#(
  parameter int GRID_COLS    = 20,
  parameter int GRID_ROWS    = 15,
  parameter int START_COL    = 9,
  parameter int START_ROW    = 14,
  parameter int HOP_FRAMES   = 8,
  parameter int DEATH_FRAMES = 30
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_clk,
  input  logic [15:0] keycode,
  input  logic        kill,
  input  logic        freeze,
  output logic [4:0]  frog_col,
  output logic [3:0]  frog_row,
  output logic [9:0]  frog_px,
  output logic [9:0]  frog_py,
  output logic [1:0]  facing,
  output logic        hopping,
  output logic        dead,
  output logic        hop_done,
  output logic        row_advance
);

  localparam int STEP = CELL_PX / HOP_FRAMES;
  localparam int HCW  = $clog2(HOP_FRAMES + 1);
  localparam int DCW  = $clog2(DEATH_FRAMES + 1);
  localparam logic [HCW-1:0] HOP_LAST  = HCW'(HOP_FRAMES - 1);
  localparam logic [DCW-1:0] DEAD_LAST = DCW'(DEATH_FRAMES - 1);

  hop_state_t     state_q, state_d;
  logic [4:0]     col_q, col_d, tgt_col_q, tgt_col_d;
  logic [3:0]     row_q, row_d, tgt_row_q, tgt_row_d;
  logic [1:0]     facing_q, facing_d;
  logic           armed_q, armed_d;
  logic [3:0]     best_row_q, best_row_d;
  logic [HCW-1:0] hop_cnt_q, hop_cnt_d;
  logic [DCW-1:0] dead_cnt_q, dead_cnt_d;
  logic           hop_done_q, hop_done_d;
  logic           row_adv_q, row_adv_d;

  logic       frame_tick;
  dir_t       key_dir;
  logic       in_bounds;
  logic [4:0] next_col;
  logic [3:0] next_row;
  logic [10:0] base_x, base_y, offset;

  frame_tick_gen u_tick (
    .Clk        (Clk),
    .Reset      (Reset),
    .frame_clk  (frame_clk),
    .frame_tick (frame_tick)
  );

  assign key_dir = decode_keycode(keycode);

  always_comb begin
    next_col  = col_q;
    next_row  = row_q;
    in_bounds = 1'b0;
    case (key_dir)
      DIR_UP: begin
        in_bounds = (row_q != 4'd0);
        next_row  = row_q - 4'd1;
      end
      DIR_DOWN: begin
        in_bounds = (int'(row_q) < GRID_ROWS - 1);
        next_row  = row_q + 4'd1;
      end
      DIR_LEFT: begin
        in_bounds = (col_q != 5'd0);
        next_col  = col_q - 5'd1;
      end
      DIR_RIGHT: begin
        in_bounds = (int'(col_q) < GRID_COLS - 1);
        next_col  = col_q + 5'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= IDLE;
      col_q      <= 5'(START_COL);
      row_q      <= 4'(START_ROW);
      tgt_col_q  <= 5'(START_COL);
      tgt_row_q  <= 4'(START_ROW);
      facing_q   <= 2'(DIR_UP);
      armed_q    <= 1'b0;
      best_row_q <= 4'(START_ROW);
      hop_cnt_q  <= '0;
      dead_cnt_q <= '0;
      hop_done_q <= 1'b0;
      row_adv_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      row_q      <= row_d;
      tgt_col_q  <= tgt_col_d;
      tgt_row_q  <= tgt_row_d;
      facing_q   <= facing_d;
      armed_q    <= armed_d;
      best_row_q <= best_row_d;
      hop_cnt_q  <= hop_cnt_d;
      dead_cnt_q <= dead_cnt_d;
      hop_done_q <= hop_done_d;
      row_adv_q  <= row_adv_d;
    end
  end

  // Kill preempts a landing on the same tick, so the frog dies in its source cell.
  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    row_d      = row_q;
    tgt_col_d  = tgt_col_q;
    tgt_row_d  = tgt_row_q;
    facing_d   = facing_q;
    armed_d    = armed_q;
    best_row_d = best_row_q;
    hop_cnt_d  = hop_cnt_q;
    dead_cnt_d = dead_cnt_q;
    hop_done_d = 1'b0;
    row_adv_d  = 1'b0;
    if (!freeze) begin
      if (kill && state_q != DEAD) begin
        state_d    = DEAD;
        dead_cnt_d = '0;
      end else if (frame_tick) begin
        case (state_q)
          IDLE: begin
            if (key_dir == DIR_NONE) begin
              armed_d = 1'b1;
            end else if (armed_q) begin
              armed_d  = 1'b0;
              facing_d = 2'(key_dir);
              if (in_bounds) begin
                tgt_col_d = next_col;
                tgt_row_d = next_row;
                hop_cnt_d = '0;
                state_d   = HOP;
              end
            end
          end
          HOP: begin
            if (key_dir == DIR_NONE) armed_d = 1'b1;
            if (hop_cnt_q == HOP_LAST) begin
              col_d      = tgt_col_q;
              row_d      = tgt_row_q;
              hop_done_d = 1'b1;
              hop_cnt_d  = '0;
              state_d    = IDLE;
              if (facing_q == 2'(DIR_UP) && tgt_row_q < best_row_q) begin
                best_row_d = tgt_row_q;
                row_adv_d  = 1'b1;
              end
            end else begin
              hop_cnt_d = hop_cnt_q + 1'b1;
            end
          end
          DEAD: begin
            if (dead_cnt_q == DEAD_LAST) begin
              col_d      = 5'(START_COL);
              row_d      = 4'(START_ROW);
              facing_d   = 2'(DIR_UP);
              armed_d    = 1'b0;
              dead_cnt_d = '0;
              state_d    = IDLE;
            end else begin
              dead_cnt_d = dead_cnt_q + 1'b1;
            end
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end

  assign base_x = {1'b0, col_q, 5'b0};
  assign base_y = {2'b0, row_q, 5'b0};
  assign offset = (state_q == HOP) ? 11'(hop_cnt_q) * 11'(STEP) : 11'd0;

  // Bounds checks on the target cell keep these sums inside the visible area.
  always_comb begin
    frog_px = 10'(base_x);
    frog_py = 10'(base_y);
    case (facing_q)
      2'd0:    frog_py = 10'($signed(base_y) - $signed(offset));
      2'd1:    frog_py = 10'($signed(base_y) + $signed(offset));
      2'd2:    frog_px = 10'($signed(base_x) - $signed(offset));
      default: frog_px = 10'($signed(base_x) + $signed(offset));
    endcase
  end

  assign frog_col    = col_q;
  assign frog_row    = row_q;
  assign facing      = facing_q;
  assign hopping     = (state_q == HOP);
  assign dead        = (state_q == DEAD);
  assign hop_done    = hop_done_q;
  assign row_advance = row_adv_q;

endmodule

// File: tb/tb_frog_hop_ctrl.sv
// Directed scoreboard bench for frog_hop_ctrl: stimulus queues expected snapshots
// and landings, a negedge monitor pops and compares them as the DUT presents them.
module tb_frog_hop_ctrl;

  localparam int FUP    = 0;
  localparam int FDOWN  = 1;
  localparam int FLEFT  = 2;
  localparam int FRIGHT = 3;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        frame_clk = 1'b0;
  logic [15:0] keycode = 16'h0000;
  logic        kill = 1'b0;
  logic        freeze = 1'b0;
  logic [4:0]  frog_col;
  logic [3:0]  frog_row;
  logic [9:0]  frog_px, frog_py;
  logic [1:0]  facing;
  logic        hopping, dead, hop_done, row_advance;

  typedef struct packed {
    logic [4:0] col;
    logic [3:0] row;
    logic [9:0] px;
    logic [9:0] py;
    logic [1:0] facing;
    logic       hopping;
    logic       dead;
  } snap_t;

  typedef struct packed {
    logic [4:0] col;
    logic [3:0] row;
    logic [1:0] facing;
    logic       rowAdv;
  } land_t;

  snap_t probeQ[$];
  string nameQ[$];
  land_t landQ[$];
  logic  probeReq = 1'b0;
  logic  finalReq = 1'b0;
  int    checks = 0;
  int    failures = 0;

  frog_hop_ctrl dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .frame_clk   (frame_clk),
    .keycode     (keycode),
    .kill        (kill),
    .freeze      (freeze),
    .frog_col    (frog_col),
    .frog_row    (frog_row),
    .frog_px     (frog_px),
    .frog_py     (frog_py),
    .facing      (facing),
    .hopping     (hopping),
    .dead        (dead),
    .hop_done    (hop_done),
    .row_advance (row_advance)
  );

  always #5 Clk = ~Clk;

  // One video frame with the key held; optionally raise kill on the edge that consumes the tick.
  task automatic applyStimulus(input logic [15:0] key, input bit killOnTick = 1'b0);
    keycode   = key;
    frame_clk = 1'b1;
    repeat (3) @(posedge Clk);
    #1 kill = killOnTick;
    @(posedge Clk);
    #1 kill = 1'b0;
    frame_clk = 1'b0;
    repeat (4) @(posedge Clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int c, input int r, input int x,
                             input int y, input int f, input int h, input int d);
    snap_t s;
    s.col     = 5'(c);
    s.row     = 4'(r);
    s.px      = 10'(x);
    s.py      = 10'(y);
    s.facing  = 2'(f);
    s.hopping = h[0];
    s.dead    = d[0];
    probeQ.push_back(s);
    nameQ.push_back(name);
    probeReq = 1'b1;
    @(negedge Clk);
    #1 probeReq = 1'b0;
  endtask

  task automatic expectLanding(input int c, input int r, input int f, input int adv);
    land_t l;
    l.col    = 5'(c);
    l.row    = 4'(r);
    l.facing = 2'(f);
    l.rowAdv = adv[0];
    landQ.push_back(l);
  endtask

  // Scoreboard monitor: landings are matched on hop_done, snapshots on probe requests.
  always @(negedge Clk) begin
    snap_t actSnap, expSnap;
    land_t expLand;
    string pname;
    if (!Reset) begin
      if (hop_done) begin
        checks++;
        if (landQ.size() == 0) begin
          failures++;
          $display("[TB] FAIL unexpectedLanding: got col=%0d row=%0d facing=%0d, required no hop_done",
                   frog_col, frog_row, facing);
        end else begin
          expLand = landQ.pop_front();
          if (frog_col !== expLand.col || frog_row !== expLand.row ||
              facing !== expLand.facing || row_advance !== expLand.rowAdv) begin
            failures++;
            $display("[TB] FAIL landing: got col=%0d row=%0d facing=%0d rowAdv=%0b, required col=%0d row=%0d facing=%0d rowAdv=%0b",
                     frog_col, frog_row, facing, row_advance,
                     expLand.col, expLand.row, expLand.facing, expLand.rowAdv);
          end
        end
      end else if (row_advance) begin
        checks++;
        failures++;
        $display("[TB] FAIL strayRowAdvance: got row_advance=1 with hop_done=0, required 0");
      end
      if (probeReq && probeQ.size() != 0) begin
        expSnap = probeQ.pop_front();
        pname   = nameQ.pop_front();
        actSnap = '{frog_col, frog_row, frog_px, frog_py, facing, hopping, dead};
        checks++;
        if (actSnap !== expSnap) begin
          failures++;
          $display("[TB] FAIL %s: got col=%0d row=%0d px=%0d py=%0d facing=%0d hop=%0b dead=%0b, required col=%0d row=%0d px=%0d py=%0d facing=%0d hop=%0b dead=%0b",
                   pname, actSnap.col, actSnap.row, actSnap.px, actSnap.py, actSnap.facing,
                   actSnap.hopping, actSnap.dead, expSnap.col, expSnap.row, expSnap.px,
                   expSnap.py, expSnap.facing, expSnap.hopping, expSnap.dead);
        end
      end
      if (finalReq) begin
        checks++;
        if (landQ.size() != 0) begin
          failures++;
          $display("[TB] FAIL pendingLandings: got %0d landings never seen, required 0", landQ.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got no end of test, required end before 1 ms");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (3) @(posedge Clk);
    #1 Reset = 1'b0;
    checkOutput("reset", 9, 14, 288, 448, FUP, 0, 0);

    // Single UP hop: arm with an empty frame, press W for one frame, then release.
    applyStimulus(16'h0000);
    applyStimulus(16'h001A);
    checkOutput("upStart", 9, 14, 288, 448, FUP, 1, 0);
    for (int i = 1; i < 8; i++) begin
      applyStimulus(16'h0000);
      checkOutput($sformatf("upStep%0d", i), 9, 14, 288, 448 - 4 * i, FUP, 1, 0);
    end
    expectLanding(9, 13, FUP, 1);
    applyStimulus(16'h0000);
    checkOutput("upLand", 9, 13, 288, 416, FUP, 0, 0);

    // Holding D for 40 frames gives exactly one hop.
    expectLanding(10, 13, FRIGHT, 0);
    repeat (40) applyStimulus(16'h0007);
    checkOutput("heldKey", 10, 13, 320, 416, FRIGHT, 0, 0);
    applyStimulus(16'h0000);

    // Walk to column 0, step down to the bottom row, then try to leave the grid.
    for (int c = 10; c > 0; c--) begin
      expectLanding(c - 1, 13, FLEFT, 0);
      applyStimulus(16'h0004);
      repeat (8) applyStimulus(16'h0000);
    end
    checkOutput("walkLeft", 0, 13, 0, 416, FLEFT, 0, 0);
    expectLanding(0, 14, FDOWN, 0);
    applyStimulus(16'h0016);
    repeat (8) applyStimulus(16'h0000);
    checkOutput("stepDown", 0, 14, 0, 448, FDOWN, 0, 0);
    applyStimulus(16'h0004);
    checkOutput("turnLeft", 0, 14, 0, 448, FLEFT, 0, 0);
    applyStimulus(16'h0000);
    applyStimulus(16'h0051);
    checkOutput("turnDown", 0, 14, 0, 448, FDOWN, 0, 0);
    applyStimulus(16'h0000);

    // Kill lands on the same edge as the final hop tick.
    applyStimulus(16'h001A);
    repeat (7) applyStimulus(16'h0000);
    checkOutput("preKill", 0, 14, 0, 420, FUP, 1, 0);
    applyStimulus(16'h0000, 1'b1);
    checkOutput("killOnLand", 0, 14, 0, 448, FUP, 0, 1);
    repeat (29) applyStimulus(16'h0007);
    checkOutput("stillDead", 0, 14, 0, 448, FUP, 0, 1);
    applyStimulus(16'h0007);
    checkOutput("respawn", 9, 14, 288, 448, FUP, 0, 0);
    repeat (3) applyStimulus(16'h0007);
    checkOutput("heldAfterRespawn", 9, 14, 288, 448, FUP, 0, 0);
    applyStimulus(16'h0000);

    // Freeze mid-hop (with a kill attempt), then resume from the same step.
    applyStimulus(16'h001A);
    repeat (3) applyStimulus(16'h0000);
    freeze = 1'b1;
    repeat (9) applyStimulus(16'h0000);
    applyStimulus(16'h0000, 1'b1);
    checkOutput("frozen", 9, 14, 288, 436, FUP, 1, 0);
    freeze = 1'b0;
    applyStimulus(16'h0000);
    checkOutput("resumed", 9, 14, 288, 432, FUP, 1, 0);
    expectLanding(9, 13, FUP, 0);
    repeat (4) applyStimulus(16'h0000);
    checkOutput("resumeLand", 9, 13, 288, 416, FUP, 0, 0);

    // Second key slot, then low-byte priority.
    expectLanding(9, 12, FUP, 1);
    applyStimulus(16'h5200);
    repeat (8) applyStimulus(16'h0000);
    checkOutput("highByteUp", 9, 12, 288, 384, FUP, 0, 0);
    expectLanding(10, 12, FRIGHT, 0);
    applyStimulus(16'h1607);
    repeat (8) applyStimulus(16'h0000);
    checkOutput("lowBytePriority", 10, 12, 320, 384, FRIGHT, 0, 0);

    finalReq = 1'b1;
  end

endmodule
